led_status_sequencer: RTL and testbench
=======================================

Name: led_status_sequencer

Overview:
Parametrised LED status controller for the O/X classifier board. It drives an N-LED bank from the training and inference status signals, using four modes arbitrated by priority: idle running light, fast training running light, completion flash with hold timer, and classification result bar. It adds three things the current inline LED logic lacks: a result snapshot taken at the request cycle, a blinking bar for low-confidence results, and a ping-pong running-light option. It replaces the inline LED always-block in top.

Parameters:
N_LED, 8, LED count; must be at least 3
STEP_IDLE, 2000000, clocks per running-light step in IDLE
STEP_TRAIN, 500000, clocks per running-light step in TRAIN
DONE_HOLD, 50000000, clocks the all-on flash is held (1 s at 50 MHz)
BLINK_HALF, 12500000, clocks per half-period of the low-confidence blink
LOW_PCT, 40, lower bound (inclusive) of the low-confidence window, in percent
HIGH_PCT, 60, upper bound (inclusive) of the low-confidence window, in percent
RUN_BOUNCE, 0, 0 = running light wraps around; 1 = running light ping-pongs

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
training_active  in  1  level; training is in progress
training_done  in  1  level; only its rising edge is used
result_req  in  1  one-cycle pulse; show the classification result (submit edge)
result_clear  in  1  one-cycle pulse; drop the result and return to IDLE
class_bit  in  1  NN decision; 1 = O, 0 = X
prob_pct  in  7  probability of O, 0..100; values above 100 are clamped to 100
led  out  N_LED  LED drive, registered
mode  out  2  current state: 0 IDLE, 1 TRAIN, 2 DONE, 3 RESULT
result_valid  out  1  high while in RESULT

Behaviour:
- Reset (asynchronous, active-high):
  - led = 0, mode = IDLE, result_valid = 0.
  - Position, step counter, hold counter and blink counter = 0; direction = up.
  - done_prev = 0. Snapshot registers = 0.
- Timing: all outputs are registered. Every input event is reflected on the outputs one clock later.
- Transition priority, evaluated each cycle:
  1. training_done rising edge (training_done=1 and done_prev=0) -> DONE from any state, including DONE itself (hold counter restarts).
  2. training_active=1 and state is not DONE -> TRAIN.
  3. result_clear while in RESULT -> IDLE. result_clear wins if it arrives in the same cycle as result_req.
  4. result_req while in IDLE or RESULT -> RESULT. This captures a snapshot of class_bit and prob_pct, and a repeated request resnapshots.
- Running light (IDLE and TRAIN):
  - On entering either state: position = 0, step counter = 0, direction = up.
  - led = one-hot(position).
  - Position advances when the step counter reaches STEP-1; the counter then returns to 0.
  - RUN_BOUNCE=0: position wraps from N_LED-1 to 0.
  - RUN_BOUNCE=1: position reverses direction at 0 and at N_LED-1, so the end LEDs are lit for one step only.
- DONE:
  - led = all ones for exactly DONE_HOLD cycles, counted from the first all-on cycle.
  - Then exits to TRAIN if training_active=1, else IDLE.
  - result_req and result_clear are ignored in DONE.
  - result_valid = 0.
- RESULT:
  - led[N_LED-1] = snapshot of class_bit.
  - k = 1 + floor(p*(N_LED-2)/100), where p is the clamped snapshot of prob_pct. k ranges from 1 to N_LED-1.
  - led[N_LED-2:0] = thermometer code with k ones from bit 0.
  - Low confidence (LOW_PCT <= p <= HIGH_PCT): the bar field toggles between the thermometer code and 0 every BLINK_HALF cycles. The bar is shown first, and the blink counter is cleared on entry and on resnapshot. class_bit LED stays steady.
- Arithmetic: p*(N_LED-2) is computed at width 7+clog2(N_LED) with no overflow. Division is by a constant 100.
- Counters are sized clog2 of their parameter, with a minimum width of 1.
- Mid-operation reset: all state is dropped immediately. The running light restarts at bit 0 one cycle after reset is deasserted.

Decomposition:
- Package led_seq_pkg:
  - mode encoding constants IDLE/TRAIN/DONE/RESULT
  - a clog2-style width function
  - a thermometer(k) function
- One sub-module, led_run_stepper: the position/step counter with the wrap/bounce option. It is instantiated once and shared by IDLE and TRAIN, with the step length selected by mode.

Test Plan:
Parameters for all scenarios: N_LED=8, STEP_IDLE=4, STEP_TRAIN=2, DONE_HOLD=10, BLINK_HALF=3.
- Reset release, idle, RUN_BOUNCE=0 -> led=0x01, then 0x02 after 4 cycles, ...; 0x80 -> 0x01 wrap at the 32-cycle period; mode=0.
- RUN_BOUNCE=1 idle -> led sequence 01,02,04,...,80,40,...,01, each step 4 cycles.
- result_req with class_bit=1, prob_pct=100 -> next cycle led=0xFF, result_valid=1. Changing prob_pct afterwards has no effect.
- Snapshot values:
  - prob_pct=0, class_bit=0 -> led=0x01
  - prob_pct=127 (clamped to 100) -> bar=0x7F
  - prob_pct=50, class_bit=1 -> led toggles between 0x8F and 0x80 every 3 cycles
- training_active=1 during RESULT -> TRAIN, result_valid=0, step every 2 cycles. Then a training_done edge -> led=0xFF for exactly 10 cycles, then TRAIN if training_active is still 1, else IDLE. result_req during DONE is ignored.
- result_req and result_clear in the same cycle while in RESULT -> IDLE. Asserting rst mid-DONE -> led=0 in the same cycle (asynchronous), then IDLE with led=0x01 after release.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED status sequencer.
// Provides:
//   mode_t        - state/mode encoding (IDLE, TRAIN, DONE, RESULT)
//   MAX_BAR       - widest thermometer code the helper can produce
//   clog2w()      - ceil(log2(value)), never smaller than 1
//   thermometer() - k ones packed from bit 0 upward
package led_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRAIN  = 2'd1,
    DONE   = 2'd2,
    RESULT = 2'd3
  } mode_t;

  localparam int MAX_BAR = 64;

  // Counter width for a parameter value. A width of zero would make the
  // counter vanish, so the floor is one bit.
  function automatic int clog2w(input int value);
    int w;
    w = 1;
    while ((longint'(1) << w) < longint'(value)) begin
      w = w + 1;
    end
    return w;
  endfunction

  // Callers cast the result down to their own bar width.
  function automatic logic [MAX_BAR-1:0] thermometer(input int unsigned k);
    logic [MAX_BAR-1:0] t;
    t = '0;
    for (int i = 0; i < MAX_BAR; i++) begin
      if (i < int'(k)) begin
        t[i] = 1'b1;
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/led_run_stepper.sv
// Running-light position generator shared by the IDLE and TRAIN modes.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   restart   - force position 0, step counter 0, direction up
//   run       - advance the step counter this cycle
//   fast      - 1 selects the TRAIN step length, 0 the IDLE step length
//   pos_next  - position that will be registered on this edge
// pos_next is exposed combinationally so the parent can register the LED
// pattern in the same edge as the position, keeping the output one clock
// behind the input event.
module led_run_stepper
  import led_seq_pkg::*;
#(
  parameter int N_LED      = 8,
  parameter int STEP_IDLE  = 2000000,
  parameter int STEP_TRAIN = 500000,
  parameter int RUN_BOUNCE = 0,
  localparam int POS_W     = clog2w(N_LED)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             run,
  input  logic             fast,
  output logic [POS_W-1:0] pos_next
);

  localparam int STEP_MAX = (STEP_IDLE > STEP_TRAIN) ? STEP_IDLE : STEP_TRAIN;
  localparam int STEP_W   = clog2w(STEP_MAX);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LED - 1);

  logic [POS_W-1:0]  pos;
  logic [STEP_W-1:0] step_cnt;
  logic [STEP_W-1:0] step_next;
  logic [STEP_W-1:0] step_last;
  logic              going_down;
  logic              down_next;

  // Step counting and position movement. In bounce mode the direction flips
  // as the end LED is left, so each end LED is lit for a single step.
  always_comb begin
    pos_next  = pos;
    step_next = step_cnt;
    down_next = going_down;
    step_last = fast ? STEP_W'(STEP_TRAIN - 1) : STEP_W'(STEP_IDLE - 1);
    if (restart) begin
      pos_next  = '0;
      step_next = '0;
      down_next = 1'b0;
    end else if (run) begin
      if (step_cnt == step_last) begin
        step_next = '0;
        if (RUN_BOUNCE == 0) begin
          pos_next = (pos == POS_LAST) ? '0 : pos + POS_W'(1);
        end else if (going_down) begin
          if (pos == '0) begin
            down_next = 1'b0;
            pos_next  = POS_W'(1);
          end else begin
            pos_next = pos - POS_W'(1);
          end
        end else begin
          if (pos == POS_LAST) begin
            down_next = 1'b1;
            pos_next  = pos - POS_W'(1);
          end else begin
            pos_next = pos + POS_W'(1);
          end
        end
      end else begin
        step_next = step_cnt + STEP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos        <= '0;
      step_cnt   <= '0;
      going_down <= 1'b0;
    end else begin
      pos        <= pos_next;
      step_cnt   <= step_next;
      going_down <= down_next;
    end
  end

endmodule

// File: rtl/led_status_sequencer.sv
// LED status controller for the O/X classifier board.
// Drives an N_LED bank from the training/inference status signals with four
// prioritised modes: idle running light, fast training running light,
// completion flash with hold timer, and classification result bar.
// Ports:
//   clk, rst         - clock and asynchronous active-high reset
//   training_active  - level, training in progress
//   training_done    - level, only its rising edge matters
//   result_req       - pulse, snapshot class_bit/prob_pct and show result
//   result_clear     - pulse, leave RESULT for IDLE
//   class_bit        - NN decision (1 = O, 0 = X)
//   prob_pct         - probability of O in percent, clamped to 100
//   led              - registered LED drive
//   mode             - current mode (0 IDLE, 1 TRAIN, 2 DONE, 3 RESULT)
//   result_valid     - high while in RESULT
module led_status_sequencer
  import led_seq_pkg::*;
#(
  parameter int N_LED      = 8,
  parameter int STEP_IDLE  = 2000000,
  parameter int STEP_TRAIN = 500000,
  parameter int DONE_HOLD  = 50000000,
  parameter int BLINK_HALF = 12500000,
  parameter int LOW_PCT    = 40,
  parameter int HIGH_PCT   = 60,
  parameter int RUN_BOUNCE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             training_active,
  input  logic             training_done,
  input  logic             result_req,
  input  logic             result_clear,
  input  logic             class_bit,
  input  logic [6:0]       prob_pct,
  output logic [N_LED-1:0] led,
  output logic [1:0]       mode,
  output logic             result_valid
);

  localparam int POS_W   = clog2w(N_LED);
  localparam int HOLD_W  = clog2w(DONE_HOLD);
  localparam int BLINK_W = clog2w(BLINK_HALF);
  localparam int PROD_W  = 7 + clog2w(N_LED);
  localparam int BAR_W   = N_LED - 1;

  mode_t              state;
  mode_t              state_next;
  logic               done_prev;
  logic               started;
  logic               done_rise;
  logic               snap_take;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [HOLD_W-1:0]  hold_next;
  logic [BLINK_W-1:0] blink_cnt;
  logic [BLINK_W-1:0] blink_cnt_next;
  logic               blink_on;
  logic               blink_on_next;
  logic               snap_class;
  logic               snap_class_next;
  logic [6:0]         snap_p;
  logic [6:0]         snap_p_next;
  logic               run_mode;
  logic               run_restart;
  logic               blink_restart;
  logic [POS_W-1:0]   pos_next;
  logic [PROD_W-1:0]  prod;
  logic [PROD_W-1:0]  bar_len;
  logic [BAR_W-1:0]   bar;
  logic               low_conf;
  logic [N_LED-1:0]   led_next;

  assign mode = state;

  // Mode arbitration. The training_done edge outranks everything, training
  // outranks the result path except while the flash is held, and a clear
  // beats a simultaneous request.
  always_comb begin
    state_next = state;
    snap_take  = 1'b0;
    done_rise  = training_done & ~done_prev;
    if (done_rise) begin
      state_next = DONE;
    end else if (training_active && (state != DONE)) begin
      state_next = TRAIN;
    end else if ((state == RESULT) && result_clear) begin
      state_next = IDLE;
    end else if (result_req && ((state == IDLE) || (state == RESULT))) begin
      state_next = RESULT;
      snap_take  = 1'b1;
    end else if ((state == DONE) && (hold_cnt == HOLD_W'(DONE_HOLD - 1))) begin
      state_next = training_active ? TRAIN : IDLE;
    end
  end

  // The first cycle after reset counts as an entry so the running light
  // starts with a full-length step at bit 0.
  assign run_mode    = (state_next == IDLE) || (state_next == TRAIN);
  assign run_restart = run_mode && ((state_next != state) || !started);

  led_run_stepper #(
    .N_LED      (N_LED),
    .STEP_IDLE  (STEP_IDLE),
    .STEP_TRAIN (STEP_TRAIN),
    .RUN_BOUNCE (RUN_BOUNCE)
  ) u_stepper (
    .clk      (clk),
    .rst      (rst),
    .restart  (run_restart),
    .run      (run_mode),
    .fast     (state_next == TRAIN),
    .pos_next (pos_next)
  );

  // Hold timer, result snapshot and blink phase. The blink restarts with the
  // bar visible both on entry to RESULT and on every resnapshot.
  always_comb begin
    hold_next       = hold_cnt;
    snap_class_next = snap_class;
    snap_p_next     = snap_p;
    blink_cnt_next  = blink_cnt;
    blink_on_next   = blink_on;
    blink_restart   = (state_next == RESULT) && ((state != RESULT) || snap_take);

    if (done_rise) begin
      hold_next = '0;
    end else if (state_next == DONE) begin
      hold_next = hold_cnt + HOLD_W'(1);
    end

    if (snap_take) begin
      snap_class_next = class_bit;
      snap_p_next     = (prob_pct > 7'd100) ? 7'd100 : prob_pct;
    end

    if (blink_restart) begin
      blink_cnt_next = '0;
      blink_on_next  = 1'b1;
    end else if (state_next == RESULT) begin
      if (blink_cnt == BLINK_W'(BLINK_HALF - 1)) begin
        blink_cnt_next = '0;
        blink_on_next  = ~blink_on;
      end else begin
        blink_cnt_next = blink_cnt + BLINK_W'(1);
      end
    end
  end

  // LED pattern for the mode being entered. The bar length is
  // 1 + floor(p*(N_LED-2)/100), giving 1..N_LED-1 lit bar LEDs.
  always_comb begin
    prod     = PROD_W'(snap_p_next) * PROD_W'(N_LED - 2);
    bar_len  = (prod / PROD_W'(100)) + PROD_W'(1);
    bar      = BAR_W'(thermometer(32'(bar_len)));
    low_conf = (snap_p_next >= 7'(LOW_PCT)) && (snap_p_next <= 7'(HIGH_PCT));
    led_next = '0;
    case (state_next)
      IDLE, TRAIN: led_next = N_LED'(1) << pos_next;
      DONE:        led_next = '1;
      RESULT: begin
        led_next[N_LED-1]   = snap_class_next;
        led_next[BAR_W-1:0] = (low_conf && !blink_on_next) ? '0 : bar;
      end
      default:     led_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      done_prev    <= 1'b0;
      started      <= 1'b0;
      hold_cnt     <= '0;
      blink_cnt    <= '0;
      blink_on     <= 1'b0;
      snap_class   <= 1'b0;
      snap_p       <= '0;
      led          <= '0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_next;
      done_prev    <= training_done;
      started      <= 1'b1;
      hold_cnt     <= hold_next;
      blink_cnt    <= blink_cnt_next;
      blink_on     <= blink_on_next;
      snap_class   <= snap_class_next;
      snap_p       <= snap_p_next;
      led          <= led_next;
      result_valid <= (state_next == RESULT);
    end
  end

endmodule

// File: tb/tb_led_status_sequencer.sv
// Scoreboard bench for led_status_sequencer. Two instances share the inputs,
// one wrapping and one ping-ponging. A driver applies directed then random
// stimulus at each falling edge and pushes the reference model's expected
// outputs; a monitor pops and compares after every rising edge.
module tb_led_status_sequencer;

  localparam int N      = 8;
  localparam int S_IDLE = 4;
  localparam int S_TRN  = 2;
  localparam int HOLD   = 10;
  localparam int BHALF  = 3;
  localparam int LOWP   = 40;
  localparam int HIGHP  = 60;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ta = 1'b0, td = 1'b0, rq = 1'b0, rc = 1'b0, cb = 1'b0;
  logic [6:0] pp = '0;
  logic [7:0] led_w, led_b;
  logic [1:0] mode_w, mode_b;
  logic       rv_w, rv_b;

  typedef struct packed {
    logic [7:0] led_wrap;
    logic [7:0] led_bounce;
    logic [1:0] mode;
    logic       rv;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  bit   pushed_any = 0;

  // Reference model: mode plus cycles elapsed since the mode was entered.
  int m_mode, m_elapsed, m_p;
  bit m_fresh, m_dprev, m_cls;

  led_status_sequencer #(
    .N_LED(N), .STEP_IDLE(S_IDLE), .STEP_TRAIN(S_TRN), .DONE_HOLD(HOLD),
    .BLINK_HALF(BHALF), .LOW_PCT(LOWP), .HIGH_PCT(HIGHP), .RUN_BOUNCE(0)
  ) dut_wrap (
    .clk(clk), .rst(rst), .training_active(ta), .training_done(td),
    .result_req(rq), .result_clear(rc), .class_bit(cb), .prob_pct(pp),
    .led(led_w), .mode(mode_w), .result_valid(rv_w)
  );

  led_status_sequencer #(
    .N_LED(N), .STEP_IDLE(S_IDLE), .STEP_TRAIN(S_TRN), .DONE_HOLD(HOLD),
    .BLINK_HALF(BHALF), .LOW_PCT(LOWP), .HIGH_PCT(HIGHP), .RUN_BOUNCE(1)
  ) dut_bounce (
    .clk(clk), .rst(rst), .training_active(ta), .training_done(td),
    .result_req(rq), .result_clear(rc), .class_bit(cb), .prob_pct(pp),
    .led(led_b), .mode(mode_b), .result_valid(rv_b)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic exp_t modelOutputs();
    exp_t e;
    int   step, s, ph, k, bar;
    e.mode = 2'(m_mode);
    e.rv   = (m_mode == 3);
    case (m_mode)
      0, 1: begin
        step = (m_mode == 0) ? S_IDLE : S_TRN;
        s    = m_elapsed / step;
        ph   = s % (2 * N - 2);
        e.led_wrap   = 8'(1 << (s % N));
        e.led_bounce = 8'(1 << ((ph < N) ? ph : (2 * N - 2 - ph)));
      end
      2: begin
        e.led_wrap   = 8'hFF;
        e.led_bounce = 8'hFF;
      end
      default: begin
        k   = 1 + (m_p * (N - 2)) / 100;
        bar = (1 << k) - 1;
        if (m_p >= LOWP && m_p <= HIGHP && ((m_elapsed / BHALF) % 2) == 1) bar = 0;
        e.led_wrap   = {m_cls, 7'(bar)};
        e.led_bounce = e.led_wrap;
      end
    endcase
    return e;
  endfunction

  task automatic modelStep(input bit r, a, d, q, c, b, input int p, output exp_t e);
    int nmode;
    bit entry;
    if (r) begin
      m_mode = 0; m_elapsed = 0; m_p = 0;
      m_fresh = 1; m_dprev = 0; m_cls = 0;
      e = '0;
    end else begin
      nmode = m_mode;
      entry = m_fresh;
      if (d && !m_dprev) begin
        nmode = 2; entry = 1;
      end else if (a && m_mode != 2) begin
        nmode = 1;
      end else if (m_mode == 3 && c) begin
        nmode = 0;
      end else if (q && (m_mode == 0 || m_mode == 3)) begin
        nmode = 3; entry = 1; m_cls = b; m_p = (p > 100) ? 100 : p;
      end else if (m_mode == 2 && m_elapsed == HOLD - 1) begin
        nmode = a ? 1 : 0;
      end
      if (nmode != m_mode) entry = 1;
      m_elapsed = entry ? 0 : m_elapsed + 1;
      m_mode    = nmode;
      m_fresh   = 0;
      m_dprev   = d;
      e = modelOutputs();
    end
  endtask

  // Pulses q and c are applied on the first cycle only; levels are held.
  task automatic applyStimulus(input bit r, a, d, q, c, b, input int p, input int cycles);
    exp_t e;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rst = r; ta = a; td = d; cb = b; pp = 7'(p);
      rq = (i == 0) ? q : 1'b0;
      rc = (i == 0) ? c : 1'b0;
      modelStep(r, a, d, rq, rc, b, p, e);
      sb.push_back(e);
      pushed_any = 1;
    end
  endtask

  task automatic asyncResetCheck();
    exp_t e;
    @(negedge clk);
    rst = 1'b1; rq = 1'b0; rc = 1'b0;
    modelStep(1, 0, 0, 0, 0, 0, 0, e);
    sb.push_back(e);
    #1;
    checkOutput("async_rst_led_wrap", 32'(led_w), 32'h0);
    checkOutput("async_rst_led_bounce", 32'(led_b), 32'h0);
    checkOutput("async_rst_mode", 32'(mode_w), 32'h0);
    checkOutput("async_rst_valid", 32'(rv_w), 32'h0);
  endtask

  // Monitor: every rising edge presents one output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("led_wrap", 32'(led_w), 32'(e.led_wrap));
        checkOutput("led_bounce", 32'(led_b), 32'(e.led_bounce));
        checkOutput("mode_wrap", 32'(mode_w), 32'(e.mode));
        checkOutput("mode_bounce", 32'(mode_b), 32'(e.mode));
        checkOutput("result_valid", 32'(rv_w), 32'(e.rv));
        checkOutput("result_valid_b", 32'(rv_b), 32'(e.rv));
      end else if (pushed_any) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL scoreboard_underflow: got empty queue, expected an entry at %0t", $time);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: got no finish, expected finish before 500000");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit a_l, d_l;
    // Reset and idle wrap / bounce
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 60);
    // Result snapshots, including clamp and low-confidence blink
    applyStimulus(0, 0, 0, 1, 0, 1, 100, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 3, 4);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 3);
    applyStimulus(0, 0, 0, 1, 0, 1, 127, 3);
    applyStimulus(0, 0, 0, 1, 0, 1, 50, 12);
    applyStimulus(0, 0, 0, 1, 0, 0, 40, 4);
    applyStimulus(0, 0, 0, 1, 0, 1, 61, 4);
    // Training during RESULT, then done flash back to TRAIN
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 8);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 3);
    applyStimulus(0, 1, 1, 1, 0, 1, 90, 1);
    applyStimulus(0, 1, 1, 0, 1, 0, 10, 10);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 3);
    // Done flash back to IDLE
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 14);
    // Request and clear together
    applyStimulus(0, 0, 1, 1, 0, 1, 70, 2);
    applyStimulus(0, 0, 1, 1, 1, 0, 20, 3);
    // Reset in the middle of DONE
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 4);
    asyncResetCheck();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 2);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 10);
    // Random traffic
    a_l = 0; d_l = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) a_l = ~a_l;
      if ($urandom_range(0, 29) == 0) d_l = ~d_l;
      applyStimulus(($urandom_range(0, 299) == 0), a_l, d_l,
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 127)), 1);
    end
    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
